// File: rtl/dest_check_arbiter_pkg.sv
// Shared definitions for the destination-check arbiter.
//   - WordWidthDefault : default destination / node ID width
//   - state_e          : 3-bit FSM state encoding
//   - clog2_f          : ceiling log2, minimum result 1 (usable for index widths)
package dest_check_arbiter_pkg;

  localparam int unsigned WordWidthDefault = 16;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StEnable = 3'd1,
    StStart  = 3'd2,
    StWait   = 3'd3,
    StResp   = 3'd4
  } state_e;

  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res = res + 1;
    end
    if (res == 0) begin
      res = 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dest_check_arbiter_if.sv
// Bundle of requester-side and engine-side signals of the destination-check arbiter.
//   slave  : arbiter view (consumes req/req_dest/engine results, drives grant/resp/engine controls)
//   master : environment view (requesters + comparison engine)
interface dest_check_arbiter_if
  import dest_check_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_WIDTH = WordWidthDefault
);

  localparam int unsigned IdxW = clog2_f(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_dest;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          resp_valid;
  logic [IdxW-1:0]               resp_id;
  logic                          resp_is_dest;
  logic                          resp_timeout;
  logic                          eng_en;
  logic                          eng_start;
  logic [WORD_WIDTH-1:0]         eng_dest_id;
  logic                          eng_iamDestination;
  logic                          eng_done;

  modport slave (
    input  req, req_dest, eng_iamDestination, eng_done,
    output grant, busy, resp_valid, resp_id, resp_is_dest, resp_timeout,
    output eng_en, eng_start, eng_dest_id
  );

  modport master (
    output req, req_dest, eng_iamDestination, eng_done,
    input  grant, busy, resp_valid, resp_id, resp_is_dest, resp_timeout,
    input  eng_en, eng_start, eng_dest_id
  );

endinterface

// File: rtl/dest_check_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req_i  : request vector
//   last_i : index of the most recently served requester
//   win_o  : one-hot winner (first set bit searching from last_i+1, wrapping)
//   idx_o  : winner index
//   any_o  : at least one request is set
module dest_check_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               any_o
);

  always_comb begin
    int unsigned k;
    logic [IdxW-1:0] kk;
    win_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    kk    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      k  = (32'(last_i) + i) % NUM_REQ;
      kk = IdxW'(k);
      if (!any_o && req_i[kk]) begin
        any_o     = 1'b1;
        win_o[kk] = 1'b1;
        idx_o     = kk;
      end
    end
  end

endmodule

// File: rtl/dest_check_arbiter.sv
// Shares one destination-check engine among NUM_REQ requesters. A round-robin
// winner's destination word is latched, the engine is sequenced through
// enable -> start -> wait-for-done, and a one-cycle tagged result is returned.
//   clock / nrst : clock, asynchronous active-low reset
//   bus (slave)  : req/req_dest in, grant/busy/resp_* out, eng_* engine handshake
// Optional build macro DCA_TIMEOUT_EN: bounds WAIT to TIMEOUT cycles and reports
// resp_timeout; without it WAIT is unbounded and resp_timeout is tied 0.
module dest_check_arbiter
  import dest_check_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_WIDTH = WordWidthDefault,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  nrst,
  dest_check_arbiter_if.slave   bus
);

  localparam int unsigned IdxW = clog2_f(NUM_REQ);

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic [WORD_WIDTH-1:0]  dest_q, dest_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   eng_en_q, eng_en_d;
  logic                   eng_start_q, eng_start_d;
  logic                   busy_q, busy_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [IdxW-1:0]        resp_id_q, resp_id_d;
  logic                   resp_is_dest_q, resp_is_dest_d;

`ifdef DCA_TIMEOUT_EN
  localparam int unsigned CntW = clog2_f(TIMEOUT + 1);
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   resp_timeout_q, resp_timeout_d;
`else
  logic                   unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
`endif

  logic [NUM_REQ-1:0]     pick_win;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_any;
  logic [WORD_WIDTH-1:0]  pick_dest;

  dest_check_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr_pick (
    .req_i  (bus.req),
    .last_i (last_q),
    .win_o  (pick_win),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Constant-index mux keeps the slice select free of width-mismatched offsets.
  always_comb begin
    pick_dest = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (pick_win[k]) begin
        pick_dest = bus.req_dest[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    last_d         = last_q;
    dest_d         = dest_q;
    grant_d        = '0;
    eng_en_d       = 1'b0;
    eng_start_d    = 1'b0;
    resp_valid_d   = 1'b0;
    resp_id_d      = resp_id_q;
    resp_is_dest_d = resp_is_dest_q;
`ifdef DCA_TIMEOUT_EN
    cnt_d          = cnt_q;
    resp_timeout_d = resp_timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          idx_d    = pick_idx;
          dest_d   = pick_dest;
          grant_d  = pick_win;
          eng_en_d = 1'b1;
          state_d  = StEnable;
        end
      end
      StEnable: begin
        eng_start_d = 1'b1;
        state_d     = StStart;
      end
      StStart: begin
        state_d = StWait;
`ifdef DCA_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        // eng_done is only trusted here; the ENABLE pulse has cleared any stale level.
        if (bus.eng_done) begin
          state_d        = StResp;
          resp_valid_d   = 1'b1;
          resp_id_d      = idx_q;
          resp_is_dest_d = bus.eng_iamDestination;
`ifdef DCA_TIMEOUT_EN
          resp_timeout_d = 1'b0;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d        = StResp;
          resp_valid_d   = 1'b1;
          resp_id_d      = idx_q;
          resp_is_dest_d = 1'b0;
          resp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StResp: begin
        last_d  = idx_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      last_q         <= IdxW'(NUM_REQ - 1);
      dest_q         <= '0;
      grant_q        <= '0;
      eng_en_q       <= 1'b0;
      eng_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_is_dest_q <= 1'b0;
`ifdef DCA_TIMEOUT_EN
      cnt_q          <= '0;
      resp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      last_q         <= last_d;
      dest_q         <= dest_d;
      grant_q        <= grant_d;
      eng_en_q       <= eng_en_d;
      eng_start_q    <= eng_start_d;
      busy_q         <= busy_d;
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
      resp_is_dest_q <= resp_is_dest_d;
`ifdef DCA_TIMEOUT_EN
      cnt_q          <= cnt_d;
      resp_timeout_q <= resp_timeout_d;
`endif
    end
  end

  assign bus.grant        = grant_q;
  assign bus.busy         = busy_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_is_dest = resp_is_dest_q;
  assign bus.eng_en       = eng_en_q;
  assign bus.eng_start    = eng_start_q;
  assign bus.eng_dest_id  = dest_q;
`ifdef DCA_TIMEOUT_EN
  assign bus.resp_timeout = resp_timeout_q;
`else
  assign bus.resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dest_check_arbiter.sv
// Self-checking bench for dest_check_arbiter: table of single transactions plus
// hand-written fairness, reset-in-WAIT and (with DCA_TIMEOUT_EN) timeout sequences.
// Expected grants/results are queued when stimulus is driven and compared by a
// monitor when the DUT pulses grant / resp_valid.
module tb_dest_check_arbiter;
  import dest_check_arbiter_pkg::*;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned TIMEOUT    = 15;
  localparam logic [15:0] NODE_ID    = 16'h00A5;
  // Drive cycle counted as the first: resp_valid lands in the sixth cycle.
  localparam int unsigned LAT_NORMAL = 5;
  localparam int unsigned LAT_TMO    = 3 + TIMEOUT;

  typedef struct {
    logic [3:0]  grant;
    logic [1:0]  id;
    logic        is_dest;
    logic        tmo;
    logic [15:0] dest;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] dest;
    logic [3:0]  grant;
    logic [1:0]  id;
    logic        is_dest;
  } vec_t;

  logic clock = 1'b0;
  logic nrst  = 1'b0;
  always #5 clock = ~clock;

  dest_check_arbiter_if #(.NUM_REQ(NUM_REQ), .WORD_WIDTH(WORD_WIDTH)) bus ();

  dest_check_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .WORD_WIDTH (WORD_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock (clock),
    .nrst  (nrst),
    .bus   (bus)
  );

  // Comparison engine model: en clears done, start arms, done follows one cycle later
  // and stays high until the next en. eng_hold keeps it from answering.
  logic eng_hold;
  logic eng_pend;
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      bus.eng_done           <= 1'b0;
      bus.eng_iamDestination <= 1'b0;
      eng_pend               <= 1'b0;
    end else if (bus.eng_en) begin
      bus.eng_done <= 1'b0;
      eng_pend     <= 1'b0;
    end else if (bus.eng_start) begin
      eng_pend <= 1'b1;
    end else if (eng_pend && !eng_hold) begin
      bus.eng_done           <= 1'b1;
      bus.eng_iamDestination <= (bus.eng_dest_id == NODE_ID);
      eng_pend               <= 1'b0;
    end
  end

  int unsigned cyc;
  always_ff @(posedge clock) cyc <= cyc + 1;

  int unsigned n_chk;
  int unsigned n_fail;
  exp_t gq[$];
  exp_t rq[$];
  exp_t mg, mr;
  int unsigned grant_cnt, resp_cnt, grant_cyc, resp_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(negedge clock) begin
    if (nrst) begin
      if (bus.grant != '0) begin
        if (gq.size() == 0) begin
          flag("unexpected grant");
        end else begin
          mg = gq.pop_front();
          check("grant", 64'(bus.grant), 64'(mg.grant));
          check("eng_dest_id at grant", 64'(bus.eng_dest_id), 64'(mg.dest));
          check("eng_en with grant", 64'(bus.eng_en), 64'd1);
        end
        grant_cyc = cyc;
        grant_cnt++;
      end
      if (bus.resp_valid) begin
        if (rq.size() == 0) begin
          flag("unexpected resp_valid");
        end else begin
          mr = rq.pop_front();
          check("resp_id", 64'(bus.resp_id), 64'(mr.id));
          check("resp_is_dest", 64'(bus.resp_is_dest), 64'(mr.is_dest));
          check("resp_timeout", 64'(bus.resp_timeout), 64'(mr.tmo));
          check("eng_dest_id held to resp", 64'(bus.eng_dest_id), 64'(mr.dest));
        end
        resp_cyc = cyc;
        resp_cnt++;
      end
    end
  end

  // kind 0: grant count reaches target; 1: resp count reaches target; 2: resp queue drained
  task automatic wait_for(input int kind, input int unsigned target, input int unsigned budget,
                          input string what);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      #1;
      case (kind)
        0:       ok = (grant_cnt >= target);
        1:       ok = (resp_cnt >= target);
        default: ok = (rq.size() == 0);
      endcase
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait %s: not seen within %0d cycles", what, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " grant"}, 64'(bus.grant), 64'd0);
    check({tag, " busy"}, 64'(bus.busy), 64'd0);
    check({tag, " resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, " resp_id"}, 64'(bus.resp_id), 64'd0);
    check({tag, " resp_is_dest"}, 64'(bus.resp_is_dest), 64'd0);
    check({tag, " resp_timeout"}, 64'(bus.resp_timeout), 64'd0);
    check({tag, " eng_en"}, 64'(bus.eng_en), 64'd0);
    check({tag, " eng_start"}, 64'(bus.eng_start), 64'd0);
    check({tag, " eng_dest_id"}, 64'(bus.eng_dest_id), 64'd0);
  endtask

  function automatic exp_t mk_exp(input logic [3:0] g, input logic [1:0] id, input logic d,
                                  input logic t, input logic [63:0] dv);
    exp_t e;
    e.grant   = g;
    e.id      = id;
    e.is_dest = d;
    e.tmo     = t;
    e.dest    = dv[id*16 +: 16];
    return e;
  endfunction

  // One request pattern: drive, hold until grant, drop, await the tagged result.
  task automatic run_txn(input logic [3:0] r, input logic [63:0] d, input exp_t e,
                         input int unsigned lat, input string name);
    int unsigned t0, gc, rc;
    @(posedge clock);
    #1;
    bus.req      = r;
    bus.req_dest = d;
    gq.push_back(e);
    rq.push_back(e);
    t0 = cyc;
    gc = grant_cnt;
    rc = resp_cnt;
    wait_for(0, gc + 1, 10, {name, " grant"});
    @(posedge clock);
    #1;
    bus.req = '0;
    wait_for(1, rc + 1, LAT_TMO + 10, {name, " resp"});
    check({name, " latency"}, 64'(resp_cyc - t0), 64'(lat));
  endtask

  vec_t tbl[8];
  int unsigned prev_g, gc0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; grant_cnt = 0; resp_cnt = 0; cyc = 0;
    bus.req = '0;
    bus.req_dest = '0;
    eng_hold = 1'b0;

    tbl[0] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h00A5}, 4'b0001, 2'd0, 1'b1};
    tbl[1] = '{4'b0100, {16'h0000, 16'h1234, 16'h0000, 16'h0000}, 4'b0100, 2'd2, 1'b0};
    tbl[2] = '{4'b1011, {16'h0011, 16'h0000, 16'h00A5, 16'h00A5}, 4'b1000, 2'd3, 1'b0};
    tbl[3] = '{4'b0011, {16'h0000, 16'h0000, 16'h00A5, 16'h0001}, 4'b0001, 2'd0, 1'b0};
    tbl[4] = '{4'b0011, {16'h0000, 16'h0000, 16'h00A5, 16'h0001}, 4'b0010, 2'd1, 1'b1};
    tbl[5] = '{4'b1000, {16'h00A5, 16'h0000, 16'h0000, 16'h0000}, 4'b1000, 2'd3, 1'b1};
    tbl[6] = '{4'b1111, {16'h00A5, 16'h00A5, 16'h00A5, 16'hFFFF}, 4'b0001, 2'd0, 1'b0};
    tbl[7] = '{4'b0101, {16'h0000, 16'h00A5, 16'h0000, 16'h00A5}, 4'b0100, 2'd2, 1'b1};

    #23;
    check_reset_outputs("reset");
    @(negedge clock);
    nrst = 1'b1;

    // Table: pointer starts at NUM_REQ-1; alternating results exercise stale done.
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].req, tbl[i].dest,
              mk_exp(tbl[i].grant, tbl[i].id, tbl[i].is_dest, 1'b0, tbl[i].dest),
              LAT_NORMAL, $sformatf("vec%0d", i));
    end

    // Fairness: all four held, pointer freshly reset.
    @(negedge clock);
    nrst = 1'b0;
    @(negedge clock);
    nrst = 1'b1;
    bus.req_dest = {4{16'h00A5}};
    gq.push_back(mk_exp(4'b0001, 2'd0, 1'b1, 1'b0, bus.req_dest));
    gq.push_back(mk_exp(4'b0010, 2'd1, 1'b1, 1'b0, bus.req_dest));
    gq.push_back(mk_exp(4'b0100, 2'd2, 1'b1, 1'b0, bus.req_dest));
    gq.push_back(mk_exp(4'b1000, 2'd3, 1'b1, 1'b0, bus.req_dest));
    gq.push_back(mk_exp(4'b0001, 2'd0, 1'b1, 1'b0, bus.req_dest));
    gq.push_back(mk_exp(4'b0010, 2'd1, 1'b1, 1'b0, bus.req_dest));
    for (int i = 0; i < 6; i++) rq.push_back(gq[i]);
    @(posedge clock);
    #1;
    bus.req = 4'b1111;
    gc0 = grant_cnt;
    prev_g = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      wait_for(0, gc0 + i + 1, 12, "fair grant");
      if (i > 0) check("grant period", 64'(grant_cyc - prev_g), 64'd6);
      prev_g = grant_cyc;
    end
    @(posedge clock);
    #1;
    bus.req = '0;
    wait_for(2, 0, 20, "fair resp drain");

    // Reset while in WAIT: no result may appear, pointer returns to NUM_REQ-1.
    eng_hold = 1'b1;
    @(posedge clock);
    #1;
    bus.req = 4'b0001;
    bus.req_dest = {16'h0, 16'h0, 16'h0, 16'h00A5};
    gq.push_back(mk_exp(4'b0001, 2'd0, 1'b1, 1'b0, bus.req_dest));
    wait_for(0, grant_cnt + 1, 10, "pre-reset grant");
    @(posedge clock);
    #1;
    bus.req = '0;
    @(negedge clock);
    @(negedge clock);
    #2;
    check("busy in WAIT", 64'(bus.busy), 64'd1);
    nrst = 1'b0;
    #1;
    check_reset_outputs("mid-WAIT reset");
    repeat (2) @(posedge clock);
    #1;
    nrst = 1'b1;
    eng_hold = 1'b0;
    repeat (4) @(posedge clock);
    run_txn(4'b0100, {16'h0, 16'h00A5, 16'h0, 16'h0},
            mk_exp(4'b0100, 2'd2, 1'b1, 1'b0, {16'h0, 16'h00A5, 16'h0, 16'h0}),
            LAT_NORMAL, "post-reset 0100");
    @(negedge clock);
    nrst = 1'b0;
    @(negedge clock);
    nrst = 1'b1;
    run_txn(4'b0101, {16'h0, 16'h00A5, 16'h0, 16'h1111},
            mk_exp(4'b0001, 2'd0, 1'b0, 1'b0, {16'h0, 16'h00A5, 16'h0, 16'h1111}),
            LAT_NORMAL, "post-reset 0101");

`ifdef DCA_TIMEOUT_EN
    // Engine silent: timeout result TIMEOUT cycles after WAIT entry, then rotation resumes.
    eng_hold = 1'b1;
    run_txn(4'b0010, {16'h0, 16'h0, 16'h00A5, 16'h0},
            mk_exp(4'b0010, 2'd1, 1'b0, 1'b1, {16'h0, 16'h0, 16'h00A5, 16'h0}),
            LAT_TMO, "timeout");
    eng_hold = 1'b0;
    run_txn(4'b0110, {16'h0, 16'h00A5, 16'h00A5, 16'h0},
            mk_exp(4'b0100, 2'd2, 1'b1, 1'b0, {16'h0, 16'h00A5, 16'h00A5, 16'h0}),
            LAT_NORMAL, "after timeout");
`endif

    repeat (3) @(posedge clock);
    if (gq.size() != 0 || rq.size() != 0) flag("scoreboard not empty at end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
